// File: rtl/seq_isqrt_pkg.sv
// -----------------------------------------------------------------------------
// seq_isqrt_pkg
//   Shared types and width helpers for the iterative integer square-root engine.
//   - state_e      : FSM state encoding (IDLE / CALC / DONE)
//   - root_width() : full-precision root width for a given radicand width
//   - cnt_width()  : bits needed for a down-counter spanning 0..n-1
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
package seq_isqrt_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_e;

   function automatic int root_width(input int in_w);
      return (in_w + 1) / 2;
   endfunction

   // A counter that runs n-1 down to 0 needs clog2(n) bits; never less than one.
   function automatic int cnt_width(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage : seq_isqrt_pkg

// File: rtl/seq_isqrt_step.sv
// -----------------------------------------------------------------------------
// seq_isqrt_step
//   One combinational iteration of the restoring digit-by-digit square root.
//   Brings down the next two radicand bits into the partial remainder, tries
//   to subtract (4*root + 1) and appends the resulting root bit.
//   Ports:
//     rem_i  [ROOT_W+1:0] partial remainder in
//     root_i [ROOT_W-1:0] partial root in
//     bits_i [1:0]        next two radicand bits (MSB first)
//     rem_o  [ROOT_W+1:0] partial remainder out
//     root_o [ROOT_W-1:0] partial root out
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module seq_isqrt_step #(
   parameter int ROOT_W = 20
) (
   input  logic [ROOT_W+1:0] rem_i,
   input  logic [ROOT_W-1:0] root_i,
   input  logic [1:0]        bits_i,
   output logic [ROOT_W+1:0] rem_o,
   output logic [ROOT_W-1:0] root_o
);

   localparam int REM_W = ROOT_W + 2;

   logic [REM_W-1:0] rem_sh;
   logic [REM_W-1:0] trial;
   logic             ge;

   // The remainder never exceeds 2*root, so dropping the two MSBs on the
   // shift loses nothing.
   assign rem_sh = REM_W'({rem_i, bits_i});
   assign trial  = {root_i, 2'b01};
   assign ge     = (rem_sh >= trial);

   assign rem_o  = ge ? (rem_sh - trial) : rem_sh;
   assign root_o = ROOT_W'({root_i, ge});

endmodule : seq_isqrt_step

// File: rtl/seq_isqrt.sv
// -----------------------------------------------------------------------------
// seq_isqrt
//   Iterative integer square root: one root bit per clock, constant latency.
//   Returns floor(sqrt(din_i)) saturated to OUT_W bits.
//   Ports:
//     clk           system clock
//     rst_n         asynchronous reset, active low
//     din_i         radicand (unsigned, IN_W bits)
//     din_update_i  start pulse; radicand sampled on the same edge
//     clr_i         synchronous clear / abort, overrides everything but reset
//     busy_o        calculation in flight (CALC or DONE)
//     dout_o        result, held until next result, clear or reset
//     sat_o         full root did not fit into OUT_W bits
//     dout_update_o one-cycle result strobe
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module seq_isqrt
   import seq_isqrt_pkg::*;
#(
   parameter int IN_W  = 40,
   parameter int OUT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [IN_W-1:0]  din_i,
   input  logic             din_update_i,
   input  logic             clr_i,
   output logic             busy_o,
   output logic [OUT_W-1:0] dout_o,
   output logic             sat_o,
   output logic             dout_update_o
);

   localparam int ROOT_W = root_width(IN_W);
   localparam int RAD_W  = 2 * ROOT_W;
   localparam int REM_W  = ROOT_W + 2;
   localparam int CNT_W  = cnt_width(ROOT_W);
   localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(ROOT_W - 1);

   state_e             state_q, state_d;
   logic [RAD_W-1:0]   rad_q,   rad_d;
   logic [REM_W-1:0]   rem_q,   rem_d;
   logic [ROOT_W-1:0]  root_q,  root_d;
   logic [CNT_W-1:0]   cnt_q,   cnt_d;
   logic [OUT_W-1:0]   dout_q,  dout_d;
   logic               sat_q,   sat_d;
   logic               upd_q,   upd_d;

   logic [REM_W-1:0]   step_rem;
   logic [ROOT_W-1:0]  step_root;
   logic               root_ovf;
   logic [OUT_W-1:0]   root_trunc;

   seq_isqrt_step #(
      .ROOT_W (ROOT_W)
   ) u_step (
      .rem_i  (rem_q),
      .root_i (root_q),
      .bits_i (rad_q[RAD_W-1 -: 2]),
      .rem_o  (step_rem),
      .root_o (step_root)
   );

   // Saturation only exists when the full root is wider than the output.
   generate
      if (ROOT_W > OUT_W) begin : g_sat
         assign root_ovf   = |root_q[ROOT_W-1:OUT_W];
         assign root_trunc = root_q[OUT_W-1:0];
      end else begin : g_nosat
         assign root_ovf   = 1'b0;
         assign root_trunc = OUT_W'(root_q);
      end
   endgenerate

   always_comb begin
      state_d = state_q;
      rad_d   = rad_q;
      rem_d   = rem_q;
      root_d  = root_q;
      cnt_d   = cnt_q;
      dout_d  = dout_q;
      sat_d   = sat_q;
      upd_d   = 1'b0;

      if (clr_i) begin
         state_d = IDLE;
         dout_d  = '0;
         sat_d   = 1'b0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (din_update_i) begin
                  // Zero-extension at the top keeps the value when IN_W is odd.
                  rad_d   = RAD_W'(din_i);
                  rem_d   = '0;
                  root_d  = '0;
                  cnt_d   = CNT_INIT;
                  state_d = CALC;
               end
            end
            CALC: begin
               rad_d  = {rad_q[RAD_W-3:0], 2'b00};
               rem_d  = step_rem;
               root_d = step_root;
               if (cnt_q == '0) begin
                  state_d = DONE;
               end else begin
                  cnt_d = cnt_q - CNT_W'(1);
               end
            end
            DONE: begin
               dout_d  = root_ovf ? '1 : root_trunc;
               sat_d   = root_ovf;
               upd_d   = 1'b1;
               state_d = IDLE;
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         rad_q   <= '0;
         rem_q   <= '0;
         root_q  <= '0;
         cnt_q   <= '0;
         dout_q  <= '0;
         sat_q   <= 1'b0;
         upd_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         rad_q   <= rad_d;
         rem_q   <= rem_d;
         root_q  <= root_d;
         cnt_q   <= cnt_d;
         dout_q  <= dout_d;
         sat_q   <= sat_d;
         upd_q   <= upd_d;
      end
   end

   // Busy covers DONE as well so a start in that cycle is never offered.
   assign busy_o        = (state_q != IDLE);
   assign dout_o        = dout_q;
   assign sat_o         = sat_q;
   assign dout_update_o = upd_q;

endmodule : seq_isqrt

// File: tb/tb_seq_isqrt.sv
`timescale 1ns/1ps
module tb_seq_isqrt;

   localparam int IN_W   = 40;
   localparam int OUT_W  = 16;
   localparam int ROOT_W = 20;
   localparam int LAT    = ROOT_W + 1;
   localparam longint unsigned OUT_MAX = 64'd65535;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic [IN_W-1:0]  din_i = '0;
   logic             din_update_i = 1'b0;
   logic             clr_i = 1'b0;
   logic             busy_o;
   logic [OUT_W-1:0] dout_o;
   logic             sat_o;
   logic             dout_update_o;

   seq_isqrt #(
      .IN_W  (IN_W),
      .OUT_W (OUT_W)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .din_i         (din_i),
      .din_update_i  (din_update_i),
      .clr_i         (clr_i),
      .busy_o        (busy_o),
      .dout_o        (dout_o),
      .sat_o         (sat_o),
      .dout_update_o (dout_update_o)
   );

   always #5 clk = ~clk;

   int unsigned cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      longint unsigned x;
      longint unsigned dout;
      longint unsigned sat;
      int unsigned     due;
   } exp_t;

   exp_t sb[$];
   int   n_tests = 0;
   int   n_fail  = 0;

   // Reference: largest r with r*r <= x, found by binary search.
   function automatic longint unsigned ref_sqrt(input longint unsigned x);
      longint unsigned lo = 0;
      longint unsigned hi = 64'd2097152;
      longint unsigned mid;
      while (lo < hi) begin
         mid = (lo + hi + 1) / 2;
         if (mid * mid <= x) lo = mid;
         else                hi = mid - 1;
      end
      return lo;
   endfunction

   task automatic check(input string name, input longint unsigned act,
                        input longint unsigned req);
      n_tests++;
      if (act != req) begin
         n_fail++;
         $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
      end
   endtask

   // Monitor: every strobe must match the oldest outstanding expectation.
   always @(negedge clk) begin
      exp_t e;
      if (rst_n && dout_update_o) begin
         if (sb.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("[TB] FAIL unexpected_strobe: got dout=%0d sat=%0d, expected no strobe (cycle %0d)",
                     dout_o, sat_o, cyc);
         end else begin
            e = sb.pop_front();
            check("dout", dout_o, e.dout);
            check("sat", sat_o, e.sat);
            check("latency", cyc, e.due);
            $display("[TB] x=%0d dout=%0d sat=%0d", e.x, dout_o, sat_o);
         end
      end
   end

   task automatic start(input longint unsigned x, input bit want);
      exp_t            e;
      longint unsigned r;
      @(negedge clk);
      din_i        = IN_W'(x);
      din_update_i = 1'b1;
      @(negedge clk);
      din_update_i = 1'b0;
      if (want) begin
         r      = ref_sqrt(x);
         e.x    = x;
         e.dout = (r > OUT_MAX) ? OUT_MAX : r;
         e.sat  = (r > OUT_MAX) ? 1 : 0;
         e.due  = cyc + LAT;
         sb.push_back(e);
      end
   endtask

   task automatic drain();
      for (int i = 0; i < 4 * LAT && sb.size() != 0; i++) @(negedge clk);
      if (sb.size() != 0) begin
         n_tests++;
         n_fail++;
         $display("[TB] FAIL strobe_timeout: got %0d pending, expected 0", sb.size());
         sb.delete();
      end
   endtask

   task automatic check_idle_zero(input string tag);
      check({tag, "_busy"}, busy_o, 0);
      check({tag, "_dout"}, dout_o, 0);
      check({tag, "_sat"}, sat_o, 0);
      check({tag, "_upd"}, dout_update_o, 0);
   endtask

   initial begin
      #5_000_000;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      longint unsigned directed [6];
      longint unsigned x, mask, r;
      int              w;
      directed[0] = 0;
      directed[1] = 15;
      directed[2] = 1;
      directed[3] = 64'd4294836225;
      directed[4] = 64'd4294836224;
      directed[5] = (64'd1 << 40) - 1;

      // Reset state
      repeat (2) @(negedge clk);
      check_idle_zero("reset");
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // Basic: 16 -> 4, busy across the calculation, result held afterwards
      start(16, 1);
      check("busy_start", busy_o, 1);
      repeat (10) @(negedge clk);
      check("busy_mid", busy_o, 1);
      drain();
      repeat (2) @(negedge clk);
      check("hold_dout", dout_o, 4);
      check("idle_busy", busy_o, 0);

      // Floor and width edges
      foreach (directed[i]) begin
         start(directed[i], 1);
         drain();
      end

      // Start during busy is ignored
      start(100, 1);
      repeat (4) @(negedge clk);
      start(49, 0);
      drain();
      repeat (LAT + 4) @(negedge clk);
      start(49, 1);
      drain();

      // Abort mid-calculation
      start(10000, 0);
      repeat (6) @(negedge clk);
      clr_i = 1'b1;
      @(negedge clk);
      clr_i = 1'b0;
      check_idle_zero("abort");
      repeat (LAT + 8) @(negedge clk);
      start(81, 1);
      drain();

      // Clear together with start: start dropped
      @(negedge clk);
      clr_i        = 1'b1;
      din_update_i = 1'b1;
      din_i        = 40'd25;
      @(negedge clk);
      clr_i        = 1'b0;
      din_update_i = 1'b0;
      check_idle_zero("clr_start");
      repeat (LAT + 4) @(negedge clk);

      // Async reset mid-calculation
      start(144, 1);
      drain();
      start(400, 0);
      repeat (5) @(negedge clk);
      #2 rst_n = 1'b0;
      #1 check_idle_zero("async_rst");
      @(negedge clk);
      rst_n = 1'b1;
      repeat (LAT + 8) @(negedge clk);

      // Random vectors, with squares and square-minus-one mixed in
      for (int i = 0; i < 2000; i++) begin
         w    = $urandom_range(1, 40);
         mask = (64'd1 << w) - 1;
         x    = {$urandom, $urandom} & mask;
         if (i % 8 == 0) begin
            r = {$urandom, $urandom} & 64'hFFFFF;
            x = r * r - ((i % 16 == 0 && r != 0) ? 1 : 0);
         end
         start(x, 1);
         drain();
      end

      repeat (4) @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule : tb_seq_isqrt
